// File: rtl/val_drain_if.sv
// val_drain_if: value-FIFO side and row-result side of val_drain.
// master drives the FIFO flags/data and sink ready; slave is val_drain.
interface val_drain_if #(
  parameter int CHANNEL_NUM = 4,
  parameter int ACC_W       = 16
);
  logic [CHANNEL_NUM-1:0]   empty;
  logic [CHANNEL_NUM*8-1:0] val_in;
  logic [CHANNEL_NUM-1:0]   val_read;
  logic [ACC_W-1:0]         sum_out;
  logic [7:0]               sum_ch;
  logic                     sum_valid;
  logic                     sum_ready;

  modport master (
    output empty,
    output val_in,
    output sum_ready,
    input  val_read,
    input  sum_out,
    input  sum_ch,
    input  sum_valid
  );

  modport slave (
    input  empty,
    input  val_in,
    input  sum_ready,
    output val_read,
    output sum_out,
    output sum_ch,
    output sum_valid
  );
endinterface

// File: rtl/val_drain.sv
// val_drain: per-channel row accumulators over value FIFOs, drained by a
// round-robin result port. Define VAL_DRAIN_SAT_EN for saturating sums.
module val_drain #(
  parameter int CHANNEL_NUM = 4,
  parameter int ROW_LEN     = 16,
  parameter int ACC_W       = 16
) (
  input logic        clk,
  input logic        rst,
  val_drain_if.slave bus
);
  localparam int PW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;
  localparam logic [15:0] LEN = 16'(ROW_LEN);
  localparam logic [PW-1:0] LAST = PW'(CHANNEL_NUM - 1);

  typedef enum logic {
    S_FETCH,
    S_DONE
  } st_t;

  st_t              r_state [CHANNEL_NUM];
  st_t              w_state_nxt [CHANNEL_NUM];
  logic [15:0]      r_cnt [CHANNEL_NUM];
  logic [ACC_W-1:0] r_acc [CHANNEL_NUM];
  logic [ACC_W-1:0] w_acc_nxt [CHANNEL_NUM];
  logic [CHANNEL_NUM-1:0] r_pend;
  logic [CHANNEL_NUM-1:0] w_rd;
  logic [CHANNEL_NUM-1:0] w_last;
  logic [CHANNEL_NUM-1:0] w_done;
  logic [CHANNEL_NUM-1:0] w_gnt;
  logic [ACC_W-1:0] w_ext;

`ifdef VAL_DRAIN_SAT_EN
  localparam logic [ACC_W-1:0] SMAX =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN =
    {1'b1, {(ACC_W-1){1'b0}}};
  logic [CHANNEL_NUM-1:0] r_sat;
  logic [CHANNEL_NUM-1:0] w_sat_nxt;
  logic [ACC_W:0]         w_wide;
`endif

  logic             w_free;
  logic             w_gnt_any;
  logic [PW-1:0]    w_gnt_idx;
  logic [PW-1:0]    r_rr;
  logic             r_valid;
  logic [ACC_W-1:0] r_sum;
  logic [7:0]       r_ch;
  int               w_j;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNEL_NUM; i++)
        r_state[i] <= S_FETCH;
    end else begin
      for (int i = 0; i < CHANNEL_NUM; i++)
        r_state[i] <= w_state_nxt[i];
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      w_state_nxt[i] = r_state[i];
      unique case (r_state[i])
        S_FETCH: if (w_last[i]) w_state_nxt[i] = S_DONE;
        S_DONE:  if (w_gnt[i])  w_state_nxt[i] = S_FETCH;
      endcase
    end
  end

  // reads are held off while rst is high, not just after the edge
  always_comb begin
    w_rd   = '0;
    w_last = '0;
    w_done = '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      w_rd[i] = ~rst & (r_state[i] == S_FETCH)
              & ~bus.empty[i] & (r_cnt[i] < LEN);
      w_last[i] = r_pend[i] & (r_cnt[i] == LEN);
      w_done[i] = (r_state[i] == S_DONE);
    end
  end

  always_comb begin
    w_ext = '0;
`ifdef VAL_DRAIN_SAT_EN
    w_wide = '0;
    w_sat_nxt = '0;
`endif
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      w_ext = {{(ACC_W-8){bus.val_in[i*8+7]}},
               bus.val_in[i*8 +: 8]};
`ifdef VAL_DRAIN_SAT_EN
      w_wide = {r_acc[i][ACC_W-1], r_acc[i]}
             + {w_ext[ACC_W-1], w_ext};
      w_acc_nxt[i] = w_wide[ACC_W-1:0];
      w_sat_nxt[i] = r_sat[i];
      if (r_sat[i]) begin
        w_acc_nxt[i] = r_acc[i];
      end else if (w_wide[ACC_W] != w_wide[ACC_W-1]) begin
        w_sat_nxt[i] = 1'b1;
        w_acc_nxt[i] = w_wide[ACC_W] ? SMIN : SMAX;
      end
`else
      w_acc_nxt[i] = r_acc[i] + w_ext;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
`ifdef VAL_DRAIN_SAT_EN
      r_sat <= '0;
`endif
      for (int i = 0; i < CHANNEL_NUM; i++) begin
        r_cnt[i] <= '0;
        r_acc[i] <= '0;
      end
    end else begin
      r_pend <= w_rd;
      for (int i = 0; i < CHANNEL_NUM; i++) begin
        if (w_gnt[i]) begin
          r_cnt[i] <= '0;
          r_acc[i] <= '0;
`ifdef VAL_DRAIN_SAT_EN
          r_sat[i] <= 1'b0;
`endif
        end else begin
          if (w_rd[i])
            r_cnt[i] <= r_cnt[i] + 16'd1;
          if (r_pend[i]) begin
            r_acc[i] <= w_acc_nxt[i];
`ifdef VAL_DRAIN_SAT_EN
            r_sat[i] <= w_sat_nxt[i];
`endif
          end
        end
      end
    end
  end

  // first DONE channel at or after r_rr, scanning with wrap
  always_comb begin
    w_free    = ~r_valid | bus.sum_ready;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_gnt     = '0;
    w_j       = 0;
    for (int k = 0; k < CHANNEL_NUM; k++) begin
      w_j = int'(r_rr) + k;
      if (w_j >= CHANNEL_NUM)
        w_j = w_j - CHANNEL_NUM;
      if (w_free && !w_gnt_any && w_done[w_j]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = PW'(w_j);
        w_gnt[w_j] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_ch    <= '0;
      r_rr    <= '0;
    end else if (w_gnt_any) begin
      r_valid <= 1'b1;
      r_sum   <= r_acc[w_gnt_idx];
      r_ch    <= 8'(w_gnt_idx);
      r_rr    <= (w_gnt_idx == LAST) ? '0
                                     : w_gnt_idx + 1'b1;
    end else if (bus.sum_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.val_read  = w_rd;
  assign bus.sum_out   = r_sum;
  assign bus.sum_ch    = r_ch;
  assign bus.sum_valid = r_valid;
endmodule

// File: tb/tb_val_drain.sv
// tb_val_drain: directed bench for val_drain; FIFO emulation feeds a
// queue-based row-sum model checked by a per-cycle compare process.
`timescale 1ns/1ps
module tb_val_drain;
  localparam int N   = 4;
  localparam int RL  = 16;
  localparam int AW  = 16;
  localparam int RL2 = 600;
`ifdef VAL_DRAIN_SAT_EN
  localparam int EXP2 = 32767;
`else
  localparam int EXP2 = 10664;
`endif

  typedef struct {
    int ch;
    int sum;
    int cyc;
    int lat;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  val_drain_if #(.CHANNEL_NUM(N), .ACC_W(AW)) bus ();
  val_drain_if #(.CHANNEL_NUM(1), .ACC_W(AW)) bus2 ();
  val_drain_if #(.CHANNEL_NUM(1), .ACC_W(AW)) bus3 ();

  val_drain #(.CHANNEL_NUM(N), .ROW_LEN(RL), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  val_drain #(.CHANNEL_NUM(1), .ROW_LEN(RL2), .ACC_W(AW)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2));
  val_drain #(.CHANNEL_NUM(1), .ROW_LEN(1), .ACC_W(AW)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3));

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [7:0]    q [N][$];
  logic [7:0]    q3 [$];
  logic [AW-1:0] exp_q [N][$];
  int            mcnt [N];
  int            msum [N];
  int            rem2 = 0;
  logic [N-1:0]  fe = '0;
  logic [N-1:0]  rd_snap = '0;
  logic          rd_snap2 = 1'b0;
  logic          rd_snap3 = 1'b0;

  rec_t          log_q [$];
  int            rd3_q [$];
  int            ridx [N];
  int            lrd [N];
  logic          pv = 1'b0;
  logic          pr = 1'b0;
  logic [AW-1:0] pout = '0;
  logic [7:0]    pch = '0;
  int            c_lat = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO emulation: pop on last cycle's read, present data after the edge
  always @(posedge clk) begin
    logic [7:0] v;
    byte sv;
    #1;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        q[i].delete();
        exp_q[i].delete();
        mcnt[i] = 0;
        msum[i] = 0;
      end
      bus.val_in = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (rd_snap[i] && q[i].size() > 0) begin
          v = q[i].pop_front();
          bus.val_in[i*8 +: 8] = v;
          sv = v;
          msum[i] += int'(sv);
          mcnt[i]++;
          if (mcnt[i] == RL) begin
            exp_q[i].push_back(AW'(msum[i]));
            mcnt[i] = 0;
            msum[i] = 0;
          end
        end
      end
      if (rd_snap2 && rem2 > 0) rem2--;
      if (rd_snap3 && q3.size() > 0) bus3.val_in = q3.pop_front();
    end
    for (int i = 0; i < N; i++)
      bus.empty[i] = (q[i].size() == 0) || fe[i];
    bus2.empty[0] = (rem2 == 0);
    bus3.empty[0] = (q3.size() == 0);
  end

  always @(negedge clk) begin
    int ch;
    rd_snap  = bus.val_read;
    rd_snap2 = bus2.val_read[0];
    rd_snap3 = bus3.val_read[0];
    if (rst) begin
      chk("rst_val_read", 32'(bus.val_read), 0);
      chk("rst_sum_valid", 32'(bus.sum_valid), 0);
      chk("rst_sum_out", 32'(bus.sum_out), 0);
      chk("rst_sum_ch", 32'(bus.sum_ch), 0);
      for (int i = 0; i < N; i++) ridx[i] = 0;
      pv = 1'b0;
      pr = 1'b0;
    end else begin
      ch = int'(bus.sum_ch);
      if (bus.sum_valid && (!pv || pr))
        c_lat = (ch < N) ? cyc - lrd[ch] : -1;
      for (int i = 0; i < N; i++) begin
        if (bus.val_read[i]) begin
          lrd[i] = cyc;
          chk("read_while_empty", 32'(bus.empty[i]), 0);
        end
      end
      if (bus3.val_read[0]) rd3_q.push_back(cyc);
      if (pv && !pr) begin
        chk("hold_valid", 32'(bus.sum_valid), 1);
        chk("hold_sum_out", 32'(bus.sum_out), 32'(pout));
        chk("hold_sum_ch", 32'(bus.sum_ch), 32'(pch));
      end
      if (bus.sum_valid && bus.sum_ready) begin
        if (ch < N && ridx[ch] < exp_q[ch].size()) begin
          chk($sformatf("result_ch%0d", ch), 32'(bus.sum_out),
              32'(exp_q[ch][ridx[ch]]));
          ridx[ch]++;
        end else begin
          checks++;
          fails++;
          $display("FAIL unexpected_result ch=%0d sum=%0d",
                   ch, bus.sum_out);
        end
        log_q.push_back('{ch, int'(bus.sum_out), cyc, c_lat});
      end
      pv   = bus.sum_valid;
      pr   = bus.sum_ready;
      pout = bus.sum_out;
      pch  = bus.sum_ch;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int ch, input int n, input logic [7:0] v);
    for (int k = 0; k < n; k++) q[ch].push_back(v);
  endtask

  task automatic wait_log(input int n, input string nm);
    int k;
    k = 0;
    while (log_q.size() < n && k < 300) begin
      tick();
      k++;
    end
    checks++;
    if (log_q.size() < n) begin
      fails++;
      $display("FAIL %s timeout results=%0d required=%0d",
               nm, log_q.size(), n);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int k;
    for (int i = 0; i < N; i++) lrd[i] = -100;
    rst = 1'b1;
    bus.empty = '1;
    bus.val_in = '0;
    bus.sum_ready = 1'b1;
    bus2.empty = 1'b1;
    bus2.val_in = 8'h7F;
    bus2.sum_ready = 1'b1;
    bus3.empty = 1'b1;
    bus3.val_in = '0;
    bus3.sum_ready = 1'b1;
    repeat (3) tick();
    chk("reset_sum_out", 32'(bus.sum_out), 0);
    chk("reset_sum_valid", 32'(bus.sum_valid), 0);
    rst = 1'b0;
    tick();

    // single row of ones on channel 0
    push(0, 16, 8'h01);
    wait_log(1, "t1");
    chk("t1_ch", log_q[0].ch, 0);
    chk("t1_sum", log_q[0].sum, 16);
    chk("t1_latency", log_q[0].lat, 3);

    // row of -1 on channel 2
    push(2, 16, 8'hFF);
    wait_log(2, "t2");
    chk("t2_ch", log_q[1].ch, 2);
    chk("t2_sum", log_q[1].sum, 32'h0000FFF0);

    // reset with a held result, a partial row and active reads
    bus.sum_ready = 1'b0;
    push(0, 16, 8'h03);
    push(3, 5, 8'h01);
    push(1, 30, 8'h01);
    repeat (25) tick();
    push(2, 8, 8'h01);
    tick();
    chk("pre_rst_val_read2", 32'(bus.val_read[2]), 1);
    chk("pre_rst_valid", 32'(bus.sum_valid), 1);
    chk("pre_rst_sum", 32'(bus.sum_out), 48);
    rst = 1'b1;
    #1;
    chk("async_rst_val_read", 32'(bus.val_read), 0);
    chk("async_rst_valid", 32'(bus.sum_valid), 0);
    chk("async_rst_sum", 32'(bus.sum_out), 0);
    tick();
    tick();
    rst = 1'b0;
    bus.sum_ready = 1'b1;
    tick();
    push(3, 16, 8'h02);
    wait_log(3, "t_rst");
    chk("t_rst_ch", log_q[2].ch, 3);
    chk("t_rst_sum", log_q[2].sum, 32);

    // all channels finish under a stalled sink, then drain
    bus.sum_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      push(i, 16, 8'(i + 1));
      push(i, 16, 8'(i + 5));
    end
    repeat (45) tick();
    chk("stall_valid", 32'(bus.sum_valid), 1);
    chk("stall_ch", 32'(bus.sum_ch), 0);
    chk("stall_sum", 32'(bus.sum_out), 16);
    n0 = log_q.size();
    bus.sum_ready = 1'b1;
    wait_log(n0 + 4, "t3_first");
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_order%0d", i), log_q[n0+i].ch, i);
      chk($sformatf("t3_sum%0d", i), log_q[n0+i].sum, 16 * (i + 1));
      chk($sformatf("t3_cycle%0d", i), log_q[n0+i].cyc - log_q[n0].cyc, i);
    end
    wait_log(n0 + 8, "t3_refill");

    // channel 1 with a toggling empty flag, data 1..16
    n0 = log_q.size();
    for (int v = 1; v <= 16; v++) q[1].push_back(8'(v));
    k = 0;
    while (log_q.size() <= n0 && k < 100) begin
      fe[1] = ~fe[1];
      tick();
      k++;
    end
    fe = '0;
    wait_log(n0 + 1, "t4");
    chk("t4_ch", log_q[n0].ch, 1);
    chk("t4_sum", log_q[n0].sum, 136);

    // long row of 0x7F on a 600-value instance
    rem2 = RL2;
    k = 0;
    while (!bus2.sum_valid && k < 800) begin
      tick();
      k++;
    end
    chk("t5_valid", 32'(bus2.sum_valid), 1);
    chk("t5_sum", 32'(bus2.sum_out), EXP2);
    chk("t5_ch", 32'(bus2.sum_ch), 0);

    // single-value rows
    q3.push_back(8'h85);
    q3.push_back(8'h02);
    k = 0;
    while (!bus3.sum_valid && k < 50) begin
      tick();
      k++;
    end
    chk("len1_first", 32'(bus3.sum_out), 32'h0000FF85);
    tick();
    k = 0;
    while (!bus3.sum_valid && k < 50) begin
      tick();
      k++;
    end
    chk("len1_second", 32'(bus3.sum_out), 2);
    chk("len1_reads", rd3_q.size(), 2);
    if (rd3_q.size() >= 2)
      chk("len1_read_gap", rd3_q[1] - rd3_q[0], 3);

    repeat (5) tick();
    for (int i = 0; i < N; i++)
      chk($sformatf("drained_ch%0d", i), ridx[i], exp_q[i].size());
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
